alu_mul_seq: RTL and testbench

- Sequential shift-add multiplier controller that sits beside the single-adder `alu`: drives its A/B/alu_control inputs and captures its y output each cycle.
- Reuses the ALU's one adder for multiplication, so no second adder or array multiplier is instantiated.
- Accepts operand pairs over a valid/ready handshake and returns the low DW bits of the product over a valid/ready handshake.

---
 rtl/alu_mul_seq.sv | 106 ++++++++++
 tb/tb_alu_mul_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier that borrows the neighbouring alu adder.
// One add (or skip) per RUN cycle; returns the low DW bits of a*b.
module alu_mul_seq #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_a,
    input  logic [DW-1:0] in_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_p,
    output logic          busy,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [1:0]    alu_control,
    input  logic [DW-1:0] alu_y
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   acc_q, acc_d;
    logic [DW-1:0]   mcand_q, mcand_d;
    logic [DW-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   mplier_sh;

    assign mplier_sh = mplier_q >> 1;

    // The alu only ever adds: accumulator plus shifted multiplicand.
    assign alu_control = 2'b00;
    assign alu_a       = acc_q;
    assign alu_b       = mcand_q;

    assign in_ready  = (state_q == IDLE) && !rst;
    assign busy      = (state_q == RUN);
    assign out_valid = (state_q == DONE);
    assign out_p     = acc_q;

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state logic: load in IDLE, shift-add in RUN, hold in DONE.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    acc_d    = '0;
                    mcand_d  = in_a;
                    mplier_d = in_b;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (mplier_q[0]) begin
                    acc_d = alu_y;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_sh;
                cnt_d    = cnt_q + CW'(1);
                // Stop early once no multiplier bits remain.
                if (cnt_q == CW'(DW - 1) || mplier_sh == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Randomised bench for alu_mul_seq with an attached adder model.
// Products and RUN lengths are predicted from plain arithmetic.
module tb_alu_mul_seq;

    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_a;
    logic [DW-1:0] in_b;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_p;
    logic          busy;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [1:0]    alu_control;
    logic [DW-1:0] alu_y;

    int checks;
    int errors;

    alu_mul_seq #(.DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_p       (out_p),
        .busy        (busy),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_control (alu_control),
        .alu_y       (alu_y)
    );

    // Behavioural single-adder alu: 00 adds, anything else subtracts.
    assign alu_y = (alu_control == 2'b00) ? alu_a + alu_b : alu_a - alu_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_prod(input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
        logic [2*DW-1:0] p;
        p = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
        return p[DW-1:0];
    endfunction

    function automatic int exp_runs(input logic [DW-1:0] b);
        int n;
        n = 1;
        for (int i = 0; i < DW; i++) begin
            if (b[i]) n = i + 1;
        end
        return n;
    endfunction

    task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input int stall, input bit trace);
        int            runs;
        int            w;
        bit            ctl_ok;
        bit            rdy_ok;
        bit            hold_ok;
        logic [DW-1:0] qa[$];
        logic [DW-1:0] qb[$];
        logic [DW-1:0] exp;
        exp       = exp_prod(a, b);
        out_ready = 1'b0;
        in_a      = a;
        in_b      = b;
        in_valid  = 1'b1;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("accept_ready", in_ready, 1);
        @(negedge clk);
        runs   = 0;
        ctl_ok = 1;
        rdy_ok = 1;
        while (busy && runs < 40) begin
            if (alu_control != 2'b00) ctl_ok = 0;
            if (in_ready) rdy_ok = 0;
            qa.push_back(alu_a);
            qb.push_back(alu_b);
            runs++;
            @(negedge clk);
        end
        check("run_cycles", runs, exp_runs(b));
        check("alu_ctl_add", ctl_ok, 1);
        check("no_ready_in_run", rdy_ok, 1);
        if (trace && runs >= 3) begin
            check("add0_a", qa[0], 0);
            check("add0_b", qb[0], 3);
            check("add1_a", qa[2], 3);
            check("add1_b", qb[2], 12);
        end
        check("out_valid", out_valid, 1);
        check("out_p", out_p, exp);
        if (stall > 0) begin
            hold_ok = 1;
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                if (!out_valid || out_p !== exp || in_ready) hold_ok = 0;
            end
            check("stall_hold", hold_ok, 1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("out_valid_drop", out_valid, 0);
        check("in_ready_back", in_ready, 1);
    endtask

    initial begin
        int w;
        logic [DW-1:0] ra;
        logic [DW-1:0] rb;
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_p", out_p, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", in_ready, 1);

        run_op(32'd3, 32'd5, 0, 1'b1);
        run_op(32'd10, 32'd20, 0, 1'b0);
        run_op(32'd0, 32'd5, 0, 1'b0);
        run_op(32'd7, 32'd0, 0, 1'b0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
        run_op(32'd6, 32'd7, 5, 1'b0);

        // Abort a long multiplication with reset.
        in_a     = 32'd100;
        in_b     = 32'd255;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        @(negedge clk);
        check("abort_busy", busy, 1);
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_busy_clr", busy, 0);
        check("abort_in_ready", in_ready, 0);
        check("abort_out_p", out_p, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_ready", in_ready, 1);
        check("post_rst_no_pulse", out_valid, 0);
        @(negedge clk);
        check("post_rst_no_pulse2", out_valid, 0);
        run_op(32'd2, 32'd3, 0, 1'b0);

        for (int n = 0; n < 1000; n++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            run_op(ra, rb, $urandom_range(0, 3), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
